multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Sequential counterpart of the combinational main-control decoder.
- Sequences one MIPS instruction over 3–5 cycles (fetch, decode, execute/memory, writeback) for a multi-cycle datapath with a shared instruction/data memory.
- Issues datapath control strobes per state.
- Waits on a memory-ready handshake for every memory access.

Parameters:
- MEM_HANDSHAKE, 1: 1 = honour mem_ready; 0 = mem_ready internally tied to 1 (single-cycle memory).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction bits 31:26 from the IR
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback select: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct field
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-low (rst_n), clock is clk. rst_n low forces state = RESET and illegal_op = 0 immediately.
- Outputs in RESET: all outputs 0.
- State encodings: RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12.
- Unused encodings: go to RESET on the next edge; all outputs 0 while in them.
- Output timing: outputs are combinational from state and op_q; the only gating is mem_ready, as noted per state. Any output not listed for a state is 0.
- RESET: all outputs 0; go to FETCH unconditionally on the first edge after rst_n rises.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write = mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - Register opcode into op_q.
  - 0x23 or 0x2B → MEM_ADDR; 0x00 → EXECUTE; 0x04 → BRANCH; 0x02 → JUMP.
  - Any other opcode → FETCH, and illegal_op=1 for exactly the next cycle (registered).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. op_q=0x23 → MEM_RD, else → MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WR:
  - mem_write=1, i_or_d=1. Hold until mem_ready=1, then → FETCH.
  - mem_write stays asserted during wait cycles; the memory must ignore the duplicate strobe until it signals ready.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.
- Latency with zero wait states, FETCH through last state inclusive:
  - R-type 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 2.
  - Each mem_ready=0 cycle adds one cycle.
- Opcode sampling: opcode is sampled only in DECODE. Later changes on opcode do not affect the in-flight instruction.
- Reset mid-operation: an in-progress memory access is abandoned and all strobes drop asynchronously. No write is issued after reset release until a new sw reaches MEM_WR.
- mem_ready outside FETCH/MEM_RD/MEM_WR: ignored.

Optional Feature:
- Macro: MULTICYCLE_ADDI_EN.
- Defined: in DECODE, opcode 0x08 → ADDI_EXEC, then ADDI_WB → FETCH (4 cycles total).
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- Undefined:
  - 0x08 is illegal (illegal_op pulse, return to FETCH).
  - Encodings 11/12 are unused and fall to RESET.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - alu_op codes, alu_src_b codes, pc_source codes
- One natural sub-module: mc_ctrl_out_decode, a purely combinational map of (state, op_q, mem_ready) to the control output bundle. The top holds the state register, op_q and illegal_op.

Test Plan:
- Reset: rst_n low for 3 cycles, release → state=0 for one cycle with all outputs 0, then state=1 with mem_read=1.
- R-type: opcode=0x00, mem_ready=1 → states 1,2,7,8,1. reg_write=1 and reg_dst=1 only in state 8; alu_op=10 in state 7.
- lw with waits: opcode=0x23, mem_ready=0 for 2 cycles in MEM_RD → states 1,2,3,4,4,4,5,1. reg_write and mem_to_reg high only in state 5.
- sw then beq: sw → states 1,2,3,6,1 with mem_write=1 only in state 6. beq (0x04) → 1,2,9,1 with pc_write_cond=1, pc_source=01 in state 9.
- Illegal opcode: opcode=0x3F → 1,2,1 with illegal_op=1 for exactly one cycle (the FETCH cycle). With MULTICYCLE_ADDI_EN, opcode=0x08 → 1,2,11,12,1.
- Reset mid-access: assert rst_n during MEM_WR with mem_ready=0 → mem_write drops to 0 in the same cycle. After release the next state sequence is 0,1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state codes, opcodes,
// datapath select codes and the control output bundle.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_RESET     = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_MEM_ADDR  = 4'd3,
      ST_MEM_RD    = 4'd4,
      ST_MEM_WB    = 4'd5,
      ST_MEM_WR    = 4'd6,
      ST_EXECUTE   = 4'd7,
      ST_R_WB      = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_JUMP      = 4'd10,
      ST_ADDI_EXEC = 4'd11,
      ST_ADDI_WB   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctl_t;

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Combinational map of current state and effective memory-ready to the control bundle.
// ADDI states decode only when MULTICYCLE_ADDI_EN is defined.
module mc_ctrl_out_decode
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic       mem_ready_i,
   output ctl_t       ctl_o
);

   always_comb begin
      ctl_o = '0;
      case (state_i)
         ST_FETCH: begin
            ctl_o.mem_read  = 1'b1;
            ctl_o.alu_src_b = SRCB_FOUR;
            ctl_o.alu_op    = ALU_ADD;
            ctl_o.pc_source = PCSRC_ALU;
            ctl_o.ir_write  = mem_ready_i;
            ctl_o.pc_write  = mem_ready_i;
         end
         ST_DECODE: begin
            ctl_o.alu_src_b = SRCB_IMM_SH2;
            ctl_o.alu_op    = ALU_ADD;
         end
         ST_MEM_ADDR: begin
            ctl_o.alu_src_a = 1'b1;
            ctl_o.alu_src_b = SRCB_IMM;
            ctl_o.alu_op    = ALU_ADD;
         end
         ST_MEM_RD: begin
            ctl_o.mem_read = 1'b1;
            ctl_o.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            ctl_o.reg_write  = 1'b1;
            ctl_o.mem_to_reg = 1'b1;
         end
         // Strobe stays high while waiting; memory ignores repeats until ready.
         ST_MEM_WR: begin
            ctl_o.mem_write = 1'b1;
            ctl_o.i_or_d    = 1'b1;
         end
         ST_EXECUTE: begin
            ctl_o.alu_src_a = 1'b1;
            ctl_o.alu_src_b = SRCB_B;
            ctl_o.alu_op    = ALU_FUNCT;
         end
         ST_R_WB: begin
            ctl_o.reg_write = 1'b1;
            ctl_o.reg_dst   = 1'b1;
         end
         ST_BRANCH: begin
            ctl_o.alu_src_a     = 1'b1;
            ctl_o.alu_src_b     = SRCB_B;
            ctl_o.alu_op        = ALU_SUB;
            ctl_o.pc_write_cond = 1'b1;
            ctl_o.pc_source     = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            ctl_o.pc_write  = 1'b1;
            ctl_o.pc_source = PCSRC_JUMP;
         end
`ifdef MULTICYCLE_ADDI_EN
         ST_ADDI_EXEC: begin
            ctl_o.alu_src_a = 1'b1;
            ctl_o.alu_src_b = SRCB_IMM;
            ctl_o.alu_op    = ALU_ADD;
         end
         ST_ADDI_WB: begin
            ctl_o.reg_write = 1'b1;
         end
`endif
         default: ctl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control FSM: state register, latched opcode and illegal-op pulse.
// Define MULTICYCLE_ADDI_EN to add the ADDI execute/writeback path.
//
//  state      | meaning
//  RESET      | idle after reset, all strobes low
//  FETCH      | read instruction at PC, PC += 4 when ready
//  DECODE     | latch opcode, precompute branch target
//  MEM_ADDR   | compute lw/sw effective address
//  MEM_RD     | data read, wait for ready
//  MEM_WB     | write MDR to rt
//  MEM_WR     | data write, wait for ready
//  EXECUTE    | R-type ALU operation
//  R_WB       | write ALUOut to rd
//  BRANCH     | beq compare and conditional PC load
//  JUMP       | PC <= jump target
//  ADDI_EXEC  | A + imm (optional)
//  ADDI_WB    | write ALUOut to rt (optional)
module multicycle_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_HANDSHAKE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state
);

   logic [3:0] state_q;
   logic [5:0] op_q;
   logic       illegal_q;
   logic       rdy;
   ctl_t       ctl;

   assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RESET;
         op_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         case (state_q)
            ST_RESET:    state_q <= ST_FETCH;
            ST_FETCH:    if (rdy) state_q <= ST_DECODE;
            ST_DECODE: begin
               op_q <= opcode;
               case (opcode)
                  OP_LW, OP_SW: state_q <= ST_MEM_ADDR;
                  OP_RTYPE:     state_q <= ST_EXECUTE;
                  OP_BEQ:       state_q <= ST_BRANCH;
                  OP_J:         state_q <= ST_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                  OP_ADDI:      state_q <= ST_ADDI_EXEC;
`endif
                  default: begin
                     state_q   <= ST_FETCH;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            ST_MEM_ADDR: state_q <= (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (rdy) state_q <= ST_MEM_WB;
            ST_MEM_WB:   state_q <= ST_FETCH;
            ST_MEM_WR:   if (rdy) state_q <= ST_FETCH;
            ST_EXECUTE:  state_q <= ST_R_WB;
            ST_R_WB:     state_q <= ST_FETCH;
            ST_BRANCH:   state_q <= ST_FETCH;
            ST_JUMP:     state_q <= ST_FETCH;
`ifdef MULTICYCLE_ADDI_EN
            ST_ADDI_EXEC: state_q <= ST_ADDI_WB;
            ST_ADDI_WB:   state_q <= ST_FETCH;
`endif
            default:     state_q <= ST_RESET;
         endcase
      end
   end

   mc_ctrl_out_decode u_out_decode (
      .state_i     (state_q),
      .mem_ready_i (rdy),
      .ctl_o       (ctl)
   );

   assign pc_write      = ctl.pc_write;
   assign pc_write_cond = ctl.pc_write_cond;
   assign i_or_d        = ctl.i_or_d;
   assign mem_read      = ctl.mem_read;
   assign mem_write     = ctl.mem_write;
   assign ir_write      = ctl.ir_write;
   assign mem_to_reg    = ctl.mem_to_reg;
   assign reg_dst       = ctl.reg_dst;
   assign reg_write     = ctl.reg_write;
   assign alu_src_a     = ctl.alu_src_a;
   assign alu_src_b     = ctl.alu_src_b;
   assign alu_op        = ctl.alu_op;
   assign pc_source     = ctl.pc_source;
   assign illegal_op    = illegal_q;
   assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Random instruction stream for multicycle_control_fsm, checked cycle by cycle
// against an instruction-level expected-cycle queue.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   multicycle_control_fsm #(.MEM_HANDSHAKE(1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
   //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
   logic [15:0] obs_ctl;
   assign obs_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

   typedef struct {
      logic [3:0] st;
      logic       rdy;
      logic [5:0] opc;
      logic       ill;
   } cyc_t;

   cyc_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic pend_ill = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected control word from the per-state strobe table.
   function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic rdy);
      logic pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, sa;
      logic [1:0] sb, aop, psrc;
      {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
      sb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         4'd1:  begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
         4'd2:  sb = 2'b11;
         4'd3:  begin sa = 1; sb = 2'b10; end
         4'd4:  begin mrd = 1; iod = 1; end
         4'd5:  begin rw = 1; m2r = 1; end
         4'd6:  begin mwr = 1; iod = 1; end
         4'd7:  begin sa = 1; aop = 2'b10; end
         4'd8:  begin rw = 1; rdst = 1; end
         4'd9:  begin sa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; end
         4'd10: begin pcw = 1; psrc = 2'b10; end
`ifdef MULTICYCLE_ADDI_EN
         4'd11: begin sa = 1; sb = 2'b10; end
         4'd12: rw = 1;
`endif
         default: ;
      endcase
      return {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, psrc};
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      if (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02) return 1;
`ifdef MULTICYCLE_ADDI_EN
      if (op == 6'h08) return 1;
`endif
      return 0;
   endfunction

   task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] opc);
      cyc_t c;
      c.st = st; c.rdy = rdy; c.opc = opc; c.ill = pend_ill;
      pend_ill = 1'b0;
      q.push_back(c);
   endtask

   function automatic logic rbit();
      return logic'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] ropc();
      return 6'($urandom_range(0, 63));
   endfunction

   // Expand one instruction into its expected cycles: fetch waits, decode, body.
   task automatic gen_instr(input logic [5:0] op, input int wf, input int wm);
      for (int i = 0; i < wf; i++) push(4'd1, 1'b0, ropc());
      push(4'd1, 1'b1, ropc());
      push(4'd2, rbit(), op);
      if (op == 6'h00) begin
         push(4'd7, rbit(), ropc());
         push(4'd8, rbit(), ropc());
      end else if (op == 6'h23) begin
         push(4'd3, rbit(), ropc());
         for (int i = 0; i < wm; i++) push(4'd4, 1'b0, ropc());
         push(4'd4, 1'b1, ropc());
         push(4'd5, rbit(), ropc());
      end else if (op == 6'h2B) begin
         push(4'd3, rbit(), ropc());
         for (int i = 0; i < wm; i++) push(4'd6, 1'b0, ropc());
         push(4'd6, 1'b1, ropc());
      end else if (op == 6'h04) begin
         push(4'd9, rbit(), ropc());
      end else if (op == 6'h02) begin
         push(4'd10, rbit(), ropc());
`ifdef MULTICYCLE_ADDI_EN
      end else if (op == 6'h08) begin
         push(4'd11, rbit(), ropc());
         push(4'd12, rbit(), ropc());
`endif
      end else begin
         pend_ill = 1'b1;
      end
   endtask

   task automatic run_queue();
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(negedge clk);
         mem_ready = c.rdy;
         opcode    = c.opc;
         #1;
         check("state", 32'(state), 32'(c.st));
         check("ctl", 32'(obs_ctl), 32'(exp_ctl(c.st, c.rdy)));
         check("illegal_op", 32'(illegal_op), 32'(c.ill));
      end
   endtask

   task automatic gen_random(input int n);
      logic [5:0] op;
      int k;
      for (int i = 0; i < n; i++) begin
         k = $urandom_range(0, 6);
         case (k)
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            4: op = 6'h02;
            5: op = 6'h08;
            default: begin
               op = ropc();
               while (is_legal(op)) op = ropc();
            end
         endcase
         gen_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_ctl", 32'(obs_ctl), 32'd0);
      check("rst_illegal", 32'(illegal_op), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst_state", 32'(state), 32'd0);
      check("post_rst_ctl", 32'(obs_ctl), 32'd0);

      // Directed patterns first, then a random mix.
      gen_instr(6'h00, 0, 0);
      gen_instr(6'h23, 0, 2);
      gen_instr(6'h2B, 0, 0);
      gen_instr(6'h04, 0, 0);
      gen_instr(6'h3F, 0, 0);
      gen_instr(6'h08, 1, 0);
      gen_instr(6'h02, 0, 0);
      gen_random(60);
      run_queue();

      // Reset while a store is waiting on memory.
      push(4'd1, 1'b1, ropc());
      push(4'd2, rbit(), 6'h2B);
      push(4'd3, rbit(), ropc());
      push(4'd6, 1'b0, ropc());
      run_queue();
      #1 rst_n = 1'b0;
      #1;
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_mem_write", 32'(mem_write), 32'd0);
      check("midrst_ctl", 32'(obs_ctl), 32'd0);
      pend_ill = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("rerst_state", 32'(state), 32'd0);
      check("rerst_mem_write", 32'(mem_write), 32'd0);
      gen_random(20);
      run_queue();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
